// File: rtl/comparison_pkg.sv
// rtl/comparison_pkg.sv - shared comparison-type enum for compare cores
package Comparison;
  typedef enum logic [1:0] {
    CMP_LT = 2'd0,
    CMP_GT = 2'd1,
    CMP_EQ = 2'd2
  } comparison_t;
endpackage

// File: rtl/posit_reduce_pkg.sv
// rtl/posit_reduce_pkg.sv - state/mode enums and NaR helper for the posit extremum reducer
package posit_reduce_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic {
    MODE_MAX = 1'b0,
    MODE_MIN = 1'b1
  } mode_t;

  // NaR is the pattern with only the sign bit set; callers slice to their width.
  function automatic logic [63:0] nar_pattern(input int width);
    return 64'd1 << (width - 1);
  endfunction
endpackage

// File: rtl/posit_compare_core.sv
// rtl/posit_compare_core.sv - combinational posit compare, NaR unordered against everything
module posit_compare_core
  import posit_reduce_pkg::*;
  import Comparison::*;
#(
  parameter int WIDTH = 8,
  parameter int ES    = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  comparison_t      comp,
  output logic             out
);

  localparam logic [WIDTH-1:0] NAR = WIDTH'(nar_pattern(WIDTH));

  // Posit ordering matches two's-complement ordering, so ES never affects the result.
  if (ES >= WIDTH) begin : g_es_exceeds_width
  end

  logic unordered;
  assign unordered = (a == NAR) || (b == NAR);

  always_comb begin
    out = 1'b0;
    if (!unordered) begin
      case (comp)
        CMP_LT:  out = $signed(a) < $signed(b);
        CMP_GT:  out = $signed(a) > $signed(b);
        CMP_EQ:  out = (a == b);
        default: out = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/posit_extremum_reducer.sv
// rtl/posit_extremum_reducer.sv - streaming max/min + index reducer; optional abort via POSIT_REDUCE_ABORT_EN
module posit_extremum_reducer
  import posit_reduce_pkg::*;
  import Comparison::*;
#(
  parameter int WIDTH     = 8,
  parameter int ES        = 1,
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 cfgValid,
  output logic                 cfgReady,
  input  logic                 cfgMode,
  input  logic [LEN_WIDTH-1:0] cfgCount,
  input  logic                 inValid,
  output logic                 inReady,
  input  logic [WIDTH-1:0]     inData,
`ifdef POSIT_REDUCE_ABORT_EN
  input  logic                 abort,
`endif
  output logic                 outValid,
  input  logic                 outReady,
  output logic [WIDTH-1:0]     outValue,
  output logic [LEN_WIDTH-1:0] outIndex,
  output logic                 outNaR,
  output logic                 outEmpty
);

  localparam logic [WIDTH-1:0] NAR = WIDTH'(nar_pattern(WIDTH));

  state_t                 state_q, state_d;
  mode_t                  mode_q;
  logic [LEN_WIDTH-1:0]   count_q, idx_q, best_idx_q;
  logic [WIDTH-1:0]       best_q;
  logic                   nar_q, empty_q;
  logic                   abort_w, accept, last_elem, better;
  comparison_t            comp_sel;

`ifdef POSIT_REDUCE_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign accept    = (state_q == ST_RUN) && inValid;
  assign last_elem = (idx_q == count_q - LEN_WIDTH'(1));
  assign comp_sel  = (mode_q == MODE_MIN) ? CMP_LT : CMP_GT;

  posit_compare_core #(.WIDTH(WIDTH), .ES(ES)) u_cmp (
    .a    (inData),
    .b    (best_q),
    .comp (comp_sel),
    .out  (better)
  );

  always_ff @(posedge clock) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cfgValid) state_d = (cfgCount == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (inValid && last_elem) state_d = ST_DONE;
      ST_DONE: if (outReady) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort_w && (state_q != ST_IDLE)) state_d = ST_IDLE;
  end

  always_comb begin
    cfgReady = (state_q == ST_IDLE);
    inReady  = (state_q == ST_RUN);
    outValid = (state_q == ST_DONE);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      mode_q     <= MODE_MAX;
      count_q    <= '0;
      idx_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      nar_q      <= 1'b0;
      empty_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cfgValid) begin
            mode_q     <= mode_t'(cfgMode);
            count_q    <= cfgCount;
            idx_q      <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            nar_q      <= 1'b0;
            empty_q    <= (cfgCount == '0);
          end
        end
        ST_RUN: begin
          if (accept) begin
            idx_q <= idx_q + LEN_WIDTH'(1);
            // Once NaR is captured the result is frozen for the rest of the job.
            if (!nar_q) begin
              if (inData == NAR) begin
                best_q     <= NAR;
                best_idx_q <= idx_q;
                nar_q      <= 1'b1;
              end else if ((idx_q == '0) || better) begin
                best_q     <= inData;
                best_idx_q <= idx_q;
              end
            end
          end
        end
        ST_DONE: if (outReady || abort_w) empty_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign outValue = best_q;
  assign outIndex = best_idx_q;
  assign outNaR   = nar_q;
  assign outEmpty = empty_q;

endmodule

// File: tb/tb_posit_extremum_reducer.sv
// tb/tb_posit_extremum_reducer.sv - scoreboard bench for posit_extremum_reducer
module tb_posit_extremum_reducer;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        cfgValid = 1'b0;
  logic        cfgReady;
  logic        cfgMode = 1'b0;
  logic [15:0] cfgCount = '0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [7:0]  inData = '0;
  logic        outValid;
  logic        outReady = 1'b1;
  logic [7:0]  outValue;
  logic [15:0] outIndex;
  logic        outNaR;
  logic        outEmpty;
`ifdef POSIT_REDUCE_ABORT_EN
  logic        abort = 1'b0;
`endif

  typedef struct packed {
    logic [7:0]  v;
    logic [15:0] i;
    logic        n;
    logic        e;
  } res_t;

  res_t sb[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  posit_extremum_reducer #(.WIDTH(8), .ES(1), .LEN_WIDTH(16)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .cfgValid (cfgValid),
    .cfgReady (cfgReady),
    .cfgMode  (cfgMode),
    .cfgCount (cfgCount),
    .inValid  (inValid),
    .inReady  (inReady),
    .inData   (inData),
`ifdef POSIT_REDUCE_ABORT_EN
    .abort    (abort),
`endif
    .outValid (outValid),
    .outReady (outReady),
    .outValue (outValue),
    .outIndex (outIndex),
    .outNaR   (outNaR),
    .outEmpty (outEmpty)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every result handshake is matched against the oldest expected result.
  always @(negedge clock) begin
    if (resetn && outValid && outReady) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=%0h required=none", outValue);
      end else begin
        res_t r;
        r = sb.pop_front();
        check("out_value", 32'(outValue), 32'(r.v));
        check("out_index", 32'(outIndex), 32'(r.i));
        check("out_nar",   32'(outNaR),   32'(r.n));
        check("out_empty", 32'(outEmpty), 32'(r.e));
      end
    end
  end

  task automatic send_cfg(input logic mode, input logic [15:0] cnt);
    int t;
    cfgValid = 1'b1;
    cfgMode  = mode;
    cfgCount = cnt;
    t = 0;
    do begin
      @(negedge clock);
      t++;
    end while (!cfgReady && t < 100);
    if (!cfgReady) check("cfg_ready_timeout", 32'(cfgReady), 32'd1);
    @(posedge clock);
    #1 cfgValid = 1'b0;
  endtask

  task automatic send_elem(input logic [7:0] d, input int gap);
    int t;
    repeat (gap) @(posedge clock);
    #1;
    inValid = 1'b1;
    inData  = d;
    t = 0;
    do begin
      @(negedge clock);
      t++;
    end while (!inReady && t < 100);
    if (!inReady) check("in_ready_timeout", 32'(inReady), 32'd1);
    @(posedge clock);
    #1 inValid = 1'b0;
  endtask

  // Elements are packed LSB-first, one byte per element.
  task automatic run_job(input logic mode, input int cnt, input logic [63:0] elems,
                         input int gap_max, input res_t exp);
    sb.push_back(exp);
    send_cfg(mode, 16'(cnt));
    for (int k = 0; k < cnt; k++)
      send_elem(elems[k*8 +: 8], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
    @(negedge clock);
    check("latency_out_valid", 32'(outValid), 32'd1);
    if (cnt == 0) begin
      check("empty_no_in_ready", 32'(inReady), 32'd0);
      check("empty_flag_live", 32'(outEmpty), 32'd1);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!cfgReady && t < 100) begin
      @(negedge clock);
      t++;
    end
    if (!cfgReady) check("idle_timeout", 32'(cfgReady), 32'd1);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clock);
    #1 resetn = 1'b1;
    @(negedge clock);
    check("rst_cfg_ready", 32'(cfgReady), 32'd1);
    check("rst_in_ready",  32'(inReady),  32'd0);
    check("rst_out_valid", 32'(outValid), 32'd0);
    check("rst_out_value", 32'(outValue), 32'd0);
    check("rst_out_index", 32'(outIndex), 32'd0);
    check("rst_out_nar",   32'(outNaR),   32'd0);
    check("rst_out_empty", 32'(outEmpty), 32'd0);
    @(posedge clock);
    #1;

    run_job(1'b0, 5, 64'h20_40_40_F0_10, 0, '{v: 8'h40, i: 16'd2, n: 1'b0, e: 1'b0});
    wait_idle();
    run_job(1'b1, 5, 64'h20_40_40_F0_10, 0, '{v: 8'hF0, i: 16'd1, n: 1'b0, e: 1'b0});
    wait_idle();
    run_job(1'b0, 4, 64'h80_7F_80_10, 0, '{v: 8'h80, i: 16'd1, n: 1'b1, e: 1'b0});
    wait_idle();
    run_job(1'b0, 0, 64'h0, 0, '{v: 8'h00, i: 16'd0, n: 1'b0, e: 1'b1});
    wait_idle();
    run_job(1'b0, 1, 64'hC0, 0, '{v: 8'hC0, i: 16'd0, n: 1'b0, e: 1'b0});
    wait_idle();

    // Backpressure: gappy input, then result held for 10 cycles.
    outReady = 1'b0;
    run_job(1'b0, 3, 64'hE0_05_30, 3, '{v: 8'h30, i: 16'd0, n: 1'b0, e: 1'b0});
    for (int c = 0; c < 10; c++) begin
      check("hold_out_valid", 32'(outValid), 32'd1);
      check("hold_cfg_ready", 32'(cfgReady), 32'd0);
      check("hold_out_value", 32'(outValue), 32'h30);
      @(negedge clock);
    end
    @(posedge clock);
    #1 outReady = 1'b1;
    wait_idle();

    // Reset after two of five elements: job discarded.
    send_cfg(1'b0, 16'd5);
    send_elem(8'h11, 0);
    send_elem(8'h22, 0);
    resetn = 1'b0;
    @(posedge clock);
    #1 resetn = 1'b1;
    @(negedge clock);
    check("midrst_cfg_ready", 32'(cfgReady), 32'd1);
    check("midrst_out_valid", 32'(outValid), 32'd0);
    check("midrst_out_value", 32'(outValue), 32'd0);
    @(posedge clock);
    #1;
    run_job(1'b0, 2, 64'h02_01, 0, '{v: 8'h02, i: 16'd1, n: 1'b0, e: 1'b0});
    wait_idle();

`ifdef POSIT_REDUCE_ABORT_EN
    send_cfg(1'b0, 16'd2);
    send_elem(8'h11, 0);
    abort = 1'b1;
    send_elem(8'h22, 0);
    abort = 1'b0;
    @(negedge clock);
    check("abort_no_valid", 32'(outValid), 32'd0);
    check("abort_cfg_ready", 32'(cfgReady), 32'd1);
    @(posedge clock);
    #1;
`endif

    repeat (5) @(negedge clock);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/posit_extremum_reducer.md
Name: posit_extremum_reducer

Overview:
Streaming controller that sequences a single posit comparator to reduce a configured-length stream of posits to its maximum or minimum, together with the index of that element. It sits between a vector source, such as an activation buffer readout, and argmax/argmin consumers. It accepts one element per cycle over valid/ready and emits one result beat per job.

Parameters:
WIDTH, 8, posit word width in bits
ES, 1, posit exponent field width (carried to the compare core; ordering does not depend on it)
LEN_WIDTH, 16, width of element count and index

Ports:
clock  input  1  rising-edge clock
resetn  input  1  synchronous active-low reset
cfgValid  input  1  job descriptor valid
cfgReady  output  1  controller can accept a descriptor
cfgMode  input  1  0 = MAX, 1 = MIN
cfgCount  input  LEN_WIDTH  number of elements in the job (0 allowed)
inValid  input  1  element valid
inReady  output  1  element accepted this cycle when high together with inValid
inData  input  WIDTH  posit element
outValid  output  1  result valid
outReady  input  1  consumer accepts result
outValue  output  WIDTH  extremum posit, or NaR
outIndex  output  LEN_WIDTH  zero-based index of the winning element
outNaR  output  1  a NaR was seen in the job
outEmpty  output  1  job had cfgCount == 0

Behaviour:
- Interface: one clock domain; reset is synchronous and active-low on clock/resetn.
- Reset values: state = IDLE, cfgReady = 1, inReady = 0, outValid = 0. outValue, outIndex, outNaR and outEmpty are all 0.
- State IDLE: cfgReady = 1, inReady = 0.
  - On cfgValid && cfgReady, latch cfgMode and cfgCount, clear the element counter and clear the NaR flag.
  - If cfgCount == 0, go to DONE with outValue = 0, outIndex = 0, outEmpty = 1, outNaR = 0.
  - Otherwise go to RUN.
- State RUN: inReady = 1, cfgReady = 0. One element is accepted per cycle on inValid.
  - Element 0 is loaded unconditionally as the current best, with index 0.
  - For element k > 0 in MAX mode, replace the best when the compare core reports GT(inData, best).
  - In MIN mode, replace the best on LT.
  - Replacement is strict, so ties keep the earliest index.
- Compare semantics: signed two's-complement ordering of the posit bit patterns.
  - NaR is the pattern with only the MSB set.
  - NaR is unordered: LT and GT return 0 against it.
- NaR handling: the first NaR accepted sets outNaR, sets the best value to NaR and captures its index. That value and index stick for the rest of the job; later NaRs do not move the index.
- Leaving RUN: when the element with index cfgCount−1 is accepted, the next cycle is DONE. Latency from the last accepted element to outValid is 1 cycle.
- State DONE: outValid = 1, and outputs hold stable while outReady = 0.
  - On outReady, return to IDLE with outValid = 0 and clear outEmpty.
  - A new descriptor is accepted no earlier than the cycle after the result handshake.
- Counter: the element counter is LEN_WIDTH bits. cfgCount = 2^LEN_WIDTH−1 is the maximum job and must not wrap.
- Reset mid-operation: reset in any state returns to IDLE with reset values. A partial job is discarded and no result beat is emitted.
- Ignored inputs: inValid is ignored outside RUN, and cfgValid is ignored outside IDLE.

Optional Feature:
POSIT_REDUCE_ABORT_EN
- When defined, adds the port "abort input 1".
  - abort high in RUN or DONE forces IDLE on the next edge with outValid = 0; no result is produced.
  - If abort and the accept of the last element happen in the same cycle, abort wins.
  - abort in IDLE has no effect.
- When not defined, the port does not exist and jobs always run to completion.

Decomposition:
- Shared package posit_reduce_pkg holds:
  - the state enum IDLE/RUN/DONE;
  - the mode enum MAX/MIN;
  - a function returning the NaR pattern for a given WIDTH.
- The comparison-type enum stays in the existing Comparison package and is reused.
- One sub-module, posit_compare_core (WIDTH, ES): a combinational a/b/comp → out compare with the NaR-unordered semantics above. The controller instantiates it once, with a = inData and b = the current best.

Test Plan:
- MAX, count 5, elements 0x10, 0xF0, 0x40, 0x40, 0x20 → outValue 0x40, outIndex 2, outNaR 0, outEmpty 0; outValid exactly 1 cycle after the last accept.
- MIN on the same stream → outValue 0xF0, outIndex 1.
- MAX, count 4, elements 0x10, 0x80, 0x7F, 0x80 → outNaR 1, outValue 0x80, outIndex 1.
- count 0 → DONE on the cycle after config with outEmpty 1, outValue 0x00, outIndex 0, and no inReady pulse. Follow with count 1, element 0xC0 → outValue 0xC0, outIndex 0.
- Backpressure: inValid toggled randomly during RUN and outReady held low for 10 cycles in DONE → result unchanged and cfgReady 0 until the handshake.
- resetn low 1 cycle after 2 of 5 elements → IDLE, cfgReady 1, no outValid. A new MAX job over 0x01, 0x02 → 0x02, index 1.
- With POSIT_REDUCE_ABORT_EN defined: abort on the cycle of the last accept → no result beat.
